// File: rtl/bcd_countdown.sv
// Microwave cook-time countdown: BCD MM:SS value decremented once per tick pulse,
// with load/start/stop control and a DONE_LEN-cycle completion pulse.
module bcd_countdown #(
    parameter logic [7:0] MAX_MIN  = 8'h99,
    parameter int         DONE_LEN = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] min_in,
    input  logic [7:0] sec_in,
    output logic [7:0] min_out,
    output logic [7:0] sec_out,
    output logic [1:0] state_o,
    output logic       running,
    output logic       zero,
    output logic       done
);

    localparam int              CW       = (DONE_LEN < 2) ? 1 : $clog2(DONE_LEN + 1);
    localparam logic [CW-1:0]   DONE_CNT = CW'(DONE_LEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_PAUSED  = 2'b01,
        S_RUNNING = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_min, r_sec, w_min_nxt, w_sec_nxt;
    logic [CW-1:0] r_done_cnt, w_done_cnt_nxt;
    logic [7:0]    w_min_ld, w_sec_ld, w_min_dig;
    logic [7:0]    w_min_dec, w_sec_dec;
    logic          w_dec_zero;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Load sanitising; BCD values order the same as their binary encodings.
    assign w_min_dig = {clamp_digit(min_in[7:4], 4'd9), clamp_digit(min_in[3:0], 4'd9)};
    assign w_min_ld  = (w_min_dig > MAX_MIN) ? MAX_MIN : w_min_dig;
    assign w_sec_ld  = {clamp_digit(sec_in[7:4], 4'd5), clamp_digit(sec_in[3:0], 4'd9)};

    // One-second BCD decrement with borrow rippling sec units -> sec tens -> min.
    always_comb begin
        w_min_dec = r_min;
        w_sec_dec = r_sec;
        if (r_sec[3:0] != 4'd0) begin
            w_sec_dec[3:0] = r_sec[3:0] - 4'd1;
        end else begin
            w_sec_dec[3:0] = 4'd9;
            if (r_sec[7:4] != 4'd0) begin
                w_sec_dec[7:4] = r_sec[7:4] - 4'd1;
            end else begin
                w_sec_dec[7:4] = 4'd5;
                if (r_min[3:0] != 4'd0) begin
                    w_min_dec[3:0] = r_min[3:0] - 4'd1;
                end else begin
                    w_min_dec[3:0] = 4'd9;
                    w_min_dec[7:4] = r_min[7:4] - 4'd1;
                end
            end
        end
    end

    assign w_dec_zero = (w_min_dec == 8'h00) && (w_sec_dec == 8'h00);

    // Priority per edge: load > stop > start > tick (clr handled in the register).
    // A load while RUNNING still consumes the edge, so a coincident tick is dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_min_nxt      = r_min;
        w_sec_nxt      = r_sec;
        w_done_cnt_nxt = (r_done_cnt != '0) ? r_done_cnt - CW'(1) : '0;
        if (load) begin
            if (r_state != S_RUNNING) begin
                w_min_nxt      = w_min_ld;
                w_sec_nxt      = w_sec_ld;
                w_state_nxt    = ((w_min_ld | w_sec_ld) != 8'h00) ? S_PAUSED : S_IDLE;
                w_done_cnt_nxt = '0;
            end
        end else if (stop) begin
            case (r_state)
                S_RUNNING: w_state_nxt = S_PAUSED;
                S_PAUSED, S_DONE: begin
                    w_state_nxt = S_IDLE;
                    w_min_nxt   = 8'h00;
                    w_sec_nxt   = 8'h00;
                end
                default: ;
            endcase
        end else if (start) begin
            if (r_state == S_PAUSED) w_state_nxt = S_RUNNING;
        end else if (tick && (r_state == S_RUNNING)) begin
            w_min_nxt = w_min_dec;
            w_sec_nxt = w_sec_dec;
            if (w_dec_zero) begin
                w_state_nxt    = S_DONE;
                w_done_cnt_nxt = DONE_CNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
            r_done_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_done_cnt <= w_done_cnt_nxt;
        end
    end

    assign min_out = r_min;
    assign sec_out = r_sec;
    assign state_o = r_state;
    assign running = (r_state == S_RUNNING);
    assign zero    = (r_min == 8'h00) && (r_sec == 8'h00);
    assign done    = (r_done_cnt != '0);

endmodule
